// File: rtl/avr_dmem_arbiter.sv
// avr_dmem_arbiter: shares one synchronous data RAM between the AVR data port and an auxiliary requester
// Ports: CLK/RST (async active-high); cpu_* is the core data port, where cpu_wait holds the core for a forced aux slot;
// aux_* is the auxiliary request/grant/read-return port; mem_* drives the single-port RAM (read data one cycle after address).
module avr_dmem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 8,
  parameter int MAX_WAIT = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          cpu_en,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_wait,
  input  logic          aux_req,
  input  logic          aux_we,
  input  logic [AW-1:0] aux_addr,
  input  logic [DW-1:0] aux_wdata,
  output logic          aux_gnt,
  output logic [DW-1:0] aux_rdata,
  output logic          aux_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_AUX} owner_t;
  logic [CW-1:0] wait_cnt;
  owner_t        rd_owner;
  logic [DW-1:0] cpu_hold, aux_hold;
  logic          force_slot, cpu_gnt;
  // Grants are gated by RST so nothing reaches the RAM while reset is held.
  always_comb begin
    force_slot = aux_req & (wait_cnt == CW'(MAX_WAIT));
    aux_gnt    = !RST & (force_slot | (!cpu_en & aux_req));
    cpu_gnt    = !RST & cpu_en & !force_slot;
    cpu_wait   = !RST & cpu_en & force_slot;
    mem_addr   = aux_gnt ? aux_addr : cpu_addr;
    mem_wdata  = aux_gnt ? aux_wdata : cpu_wdata;
    mem_we     = aux_gnt ? aux_we : (cpu_gnt & cpu_we);
    cpu_rdata  = (rd_owner == OWN_CPU) ? mem_rdata : cpu_hold;
    aux_rdata  = (rd_owner == OWN_AUX) ? mem_rdata : aux_hold;
    aux_rvalid = (rd_owner == OWN_AUX);
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt <= '0;
      rd_owner <= OWN_NONE;
      cpu_hold <= '0;
      aux_hold <= '0;
    end else begin
      wait_cnt <= (aux_gnt | !aux_req) ? '0 : (wait_cnt == CW'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1;
      rd_owner <= (cpu_gnt & !cpu_we) ? OWN_CPU : (aux_gnt & !aux_we) ? OWN_AUX : OWN_NONE;
      if (rd_owner == OWN_CPU) cpu_hold <= mem_rdata;
      if (rd_owner == OWN_AUX) aux_hold <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_avr_dmem_arbiter.sv
// tb_avr_dmem_arbiter: directed vectors plus starvation, collision and reset sequences against a behavioural RAM
module tb_avr_dmem_arbiter;
  logic        CLK = 1'b0, RST = 1'b1;
  logic        cpu_en = 1'b0, cpu_we = 1'b0, aux_req = 1'b0, aux_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0, aux_addr = 16'h0;
  logic [7:0]  cpu_wdata = 8'h0, aux_wdata = 8'h0;
  logic [7:0]  cpu_rdata, aux_rdata, mem_wdata;
  logic [7:0]  mem_rdata = 8'h0;
  logic        cpu_wait, aux_gnt, aux_rvalid, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  ram [0:65535];
  int          checks = 0, errors = 0;

  avr_dmem_arbiter #(.AW(16), .DW(8), .MAX_WAIT(8)) dut (
    .CLK(CLK), .RST(RST),
    .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rdata(aux_rdata), .aux_rvalid(aux_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic ce, cw; logic [15:0] ca; logic [7:0] cd;
    logic ar, aw; logic [15:0] aa; logic [7:0] ad;
    logic gnt, wt, we; logic [15:0] ma; logic [7:0] cr, arr; logic rv;
  } vec_t;
  vec_t v [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ce, input logic cw, input logic [15:0] ca, input logic [7:0] cd,
                       input logic ar, input logic aw, input logic [15:0] aa, input logic [7:0] ad);
    @(negedge CLK);
    cpu_en = ce; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    aux_req = ar; aux_we = aw; aux_addr = aa; aux_wdata = ad;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0200] = 8'h3C;
    ram[16'h0010] = 8'h5A;
    ram[16'h0020] = 8'hC3;
    //      ce    cw    ca        cd     ar    aw    aa        ad     gnt   wt    we    ma        cr     arr    rv
    v[0]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b0};
    v[1]  = '{1'b1, 1'b1, 16'h0100, 8'hA5, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0100, 8'h00, 8'h00, 1'b0};
    v[2]  = '{1'b1, 1'b0, 16'h0100, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0100, 8'h00, 8'h00, 1'b0};
    v[3]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'hA5, 8'h00, 1'b0};
    v[4]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0200, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0200, 8'hA5, 8'h00, 1'b0};
    v[5]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'hA5, 8'h3C, 1'b1};
    v[6]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'hA5, 8'h3C, 1'b0};
    v[7]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'hA5, 8'h3C, 1'b0};
    v[8]  = '{1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0010, 8'hA5, 8'h3C, 1'b0};
    v[9]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0020, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0020, 8'h5A, 8'h3C, 1'b0};
    v[10] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h5A, 8'hC3, 1'b1};
    v[11] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h5A, 8'hC3, 1'b0};
    v[12] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0500, 8'h99, 1'b1, 1'b0, 1'b1, 16'h0500, 8'h5A, 8'hC3, 1'b0};
    v[13] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0500, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0500, 8'h5A, 8'hC3, 1'b0};
    v[14] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h5A, 8'h99, 1'b1};
    v[15] = '{1'b1, 1'b0, 16'h0010, 8'h00, 1'b1, 1'b1, 16'h0600, 8'hEE, 1'b0, 1'b0, 1'b0, 16'h0010, 8'h5A, 8'h99, 1'b0};
    v[16] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h5A, 8'h99, 1'b0};

    // Reset state with a CPU write presented: nothing may reach the RAM.
    drive(1'b1, 1'b1, 16'h0123, 8'h55, 1'b1, 1'b1, 16'h0456, 8'h66);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_aux_gnt", aux_gnt, 0);
    chk("rst_cpu_wait", cpu_wait, 0);
    chk("rst_mem_addr", mem_addr, 16'h0123);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_aux_rdata", aux_rdata, 0);
    chk("rst_aux_rvalid", aux_rvalid, 0);
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    RST = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(v[i].ce, v[i].cw, v[i].ca, v[i].cd, v[i].ar, v[i].aw, v[i].aa, v[i].ad);
      chk($sformatf("v%0d_aux_gnt", i), aux_gnt, v[i].gnt);
      chk($sformatf("v%0d_cpu_wait", i), cpu_wait, v[i].wt);
      chk($sformatf("v%0d_mem_we", i), mem_we, v[i].we);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, v[i].ma);
      chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, v[i].cr);
      chk($sformatf("v%0d_aux_rdata", i), aux_rdata, v[i].arr);
      chk($sformatf("v%0d_aux_rvalid", i), aux_rvalid, v[i].rv);
    end

    // Starvation: one forced aux slot every MAX_WAIT+1 cycles while the CPU hammers.
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0300, 8'h77);
      chk($sformatf("starve%0d_aux_gnt", i), aux_gnt, (i % 9 == 8));
      chk($sformatf("starve%0d_cpu_wait", i), cpu_wait, (i % 9 == 8));
      chk($sformatf("starve%0d_mem_we", i), mem_we, (i % 9 == 8));
    end
    drive(1'b1, 1'b0, 16'h0300, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    chk("starve_wait_cnt", dut.wait_cnt, 0);
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    chk("starve_readback", cpu_rdata, 8'h77);

    // Collision: forced aux write beats a CPU write to the same address; the CPU write follows.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0400, 8'h22);
      chk($sformatf("coll_pre%0d_aux_gnt", i), aux_gnt, 0);
    end
    drive(1'b1, 1'b1, 16'h0400, 8'h11, 1'b1, 1'b1, 16'h0400, 8'h22);
    chk("coll_aux_gnt", aux_gnt, 1);
    chk("coll_cpu_wait", cpu_wait, 1);
    chk("coll_mem_we", mem_we, 1);
    chk("coll_mem_wdata", mem_wdata, 8'h22);
    drive(1'b1, 1'b1, 16'h0400, 8'h11, 1'b0, 1'b0, 16'h0000, 8'h00);
    chk("coll2_aux_gnt", aux_gnt, 0);
    chk("coll2_cpu_wait", cpu_wait, 0);
    chk("coll2_mem_we", mem_we, 1);
    chk("coll2_mem_wdata", mem_wdata, 8'h11);
    drive(1'b1, 1'b0, 16'h0400, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    chk("coll_final", cpu_rdata, 8'h11);

    // Reset in the middle of an aux read address cycle, with the starvation counter non-zero.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0200, 8'h00);
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0200, 8'h00);
    chk("mid_aux_gnt", aux_gnt, 1);
    RST = 1'b1;
    #1;
    chk("mid_rst_aux_gnt", aux_gnt, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_aux_rvalid", aux_rvalid, 0);
    chk("mid_rst_cpu_rdata", cpu_rdata, 0);
    chk("mid_rst_aux_rdata", aux_rdata, 0);
    chk("mid_rst_mem_addr", mem_addr, 16'h0000);
    chk("mid_rst_wait_cnt", dut.wait_cnt, 0);
    @(negedge CLK);
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
      chk($sformatf("post_rst%0d_aux_rvalid", i), aux_rvalid, 0);
      chk($sformatf("post_rst%0d_aux_rdata", i), aux_rdata, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/avr_dmem_arbiter.md
# avr_dmem_arbiter

Shares the single-port synchronous data RAM between the AVR core's data port and an auxiliary requester (debug/loader/DMA). The CPU has fixed priority. A starvation counter forces one auxiliary slot after `MAX_WAIT` refused cycles, and `cpu_wait` holds the core for that cycle. The block sits between `avr_cpu` (`d_addr`/`data_out`/`data_write`/`data_in`, with `stall` OR'd from `cpu_wait`) and the RAM macro.

## Interface
- `AW`, 16: address width.
- `DW`, 8: data width.
- `MAX_WAIT`, 8: refused auxiliary cycles before a forced auxiliary slot (≥1). Counter width is `$clog2(MAX_WAIT+1)`.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `cpu_en` in 1: CPU access request this cycle.
- `cpu_we` in 1: CPU write (1) or read (0).
- `cpu_addr` in AW: CPU address.
- `cpu_wdata` in DW: CPU write data.
- `cpu_rdata` out DW: CPU read data.
- `cpu_wait` out 1: CPU access refused this cycle; the CPU must hold the request.
- `aux_req` in 1: auxiliary request. Hold it with `aux_we`/`aux_addr`/`aux_wdata` stable until accepted.
- `aux_we` in 1: auxiliary write/read.
- `aux_addr` in AW: auxiliary address.
- `aux_wdata` in DW: auxiliary write data.
- `aux_gnt` out 1: auxiliary access accepted at this rising edge.
- `aux_rdata` out DW: auxiliary read data.
- `aux_rvalid` out 1: `aux_rdata` carries the result of the last granted auxiliary read.
- `mem_addr` out AW: RAM address.
- `mem_we` out 1: RAM write enable.
- `mem_wdata` out DW: RAM write data.
- `mem_rdata` in DW: RAM read data, valid the cycle after the address edge.

## Operation
- Define `force = aux_req & (wait_cnt == MAX_WAIT)`.
- Grant is combinational, evaluated each cycle in this order:
  - `force`: the auxiliary requester wins. `aux_gnt=1`. If `cpu_en`, then `cpu_wait=1` and the CPU access is not performed.
  - else `cpu_en`: the CPU wins. `aux_gnt=0`, `cpu_wait=0`.
  - else `aux_req`: the auxiliary requester wins. `aux_gnt=1`.
  - else no grant.
- RAM mux:
  - The granted port drives `mem_addr`, `mem_wdata` and `mem_we`.
  - With no grant: `mem_addr=cpu_addr`, `mem_wdata=cpu_wdata`, `mem_we=0`.
- Starvation counter `wait_cnt` is registered:
  - cleared when `aux_gnt` or `!aux_req`;
  - otherwise +1, saturating at `MAX_WAIT`.
- Read owner register `rd_owner` ∈ {NONE, CPU, AUX}:
  - CPU on a granted CPU read;
  - AUX on a granted auxiliary read;
  - NONE otherwise, including writes and idle cycles.
- Read data return:
  - `cpu_rdata = (rd_owner==CPU) ? mem_rdata : cpu_hold`. `cpu_hold` captures `mem_rdata` at each edge where `rd_owner==CPU`.
  - `aux_rdata` works the same way, with `aux_hold` and `rd_owner==AUX`.
  - `aux_rvalid = (rd_owner==AUX)`.
- Writes never produce `aux_rvalid`.
- Simultaneous CPU write and forced auxiliary slot: the auxiliary access wins. The CPU write is deferred by exactly one cycle, provided the CPU holds it.
- Reset values:
  - `wait_cnt=0`, `rd_owner=NONE`, `cpu_hold=0`, `aux_hold=0`.
  - While `RST` is high: `mem_we=0`, `aux_gnt=0`, `cpu_wait=0`, `aux_rvalid=0`, `cpu_rdata=0`, `aux_rdata=0`, `mem_addr=cpu_addr`.
- Reset mid-read: the pending return is discarded. No `aux_rvalid` follows reset.

## Timing
- Grant, `cpu_wait` and mem outputs are combinational from inputs and `wait_cnt`; no added address latency.
- Read latency:
  - address edge at cycle N;
  - `cpu_rdata`/`aux_rdata` valid during cycle N+1 (same cycle as `mem_rdata`);
  - held thereafter until the next read by the same owner.
- A continuously requesting auxiliary port with `cpu_en` held high is granted exactly once every `MAX_WAIT+1` cycles. The CPU loses exactly that one cycle.
- `wait_cnt` is updated on the edge. The forced grant occurs in the cycle after `wait_cnt` reaches `MAX_WAIT`.
- Back-to-back auxiliary grants are allowed on idle CPU cycles, one per cycle.
- Asynchronous reset assertion clears all registers immediately. Deassertion is taken at the next edge.

## Test plan
- CPU-only traffic: write `0xA5` to `0x0100`, then read `0x0100` → `mem_we` pulses once; `cpu_rdata=0xA5` in the cycle after the read; `cpu_wait` stays 0 and `aux_gnt` stays 0.
- Auxiliary-only: `aux_req` read of `0x0200` (RAM holds `0x3C`), `cpu_en=0` → `aux_gnt` in the same cycle; `aux_rvalid=1` and `aux_rdata=0x3C` next cycle; `aux_rdata` still `0x3C` two cycles later with `aux_rvalid=0`.
- Starvation, `MAX_WAIT=8`: `cpu_en` held high, `aux_req` write `0x77` to `0x0300` →
  - `aux_gnt` low for 8 cycles, then high for 1 cycle;
  - `cpu_wait=1` in that cycle only;
  - `0x0300` reads `0x77`; `wait_cnt` returns to 0.
- Collision: CPU write `0x11` and forced auxiliary write `0x22`, both to `0x0400`, in the same cycle, with the CPU holding its request → auxiliary wins first; CPU write lands the next cycle; final value `0x11`.
- Interleave: CPU read `0x10` at cycle N, auxiliary read `0x20` at N+1 → `cpu_rdata=mem[0x10]` at N+1 and held; `aux_rvalid` at N+2 with `mem[0x20]`; `cpu_rdata` unchanged at N+2.
- Reset mid-operation: assert `RST` during an auxiliary read address cycle, between edges →
  - `mem_we`, `aux_gnt`, `aux_rvalid` go 0 immediately;
  - both rdata outputs read 0;
  - no `aux_rvalid` after release;
  - `wait_cnt=0`.
